// File: rtl/dffsn_stim_checker_if.sv
// Stimulus/observation bundle between the checker and a DFF with
// active-low async set (pins D, SN, CLKN, Q, QN).
//   start          : one-cycle run request (into the checker)
//   D_o/SN_o/CLKN_o: flop drives (out of the checker)
//   Q_i/QN_i       : flop outputs (into the checker)
//   busy/done/pass : run status (out of the checker)
//   err_count      : saturating mismatch count (out of the checker)
// master = checker side, slave = flop/bench side.
interface dffsn_stim_checker_if;
    logic       start;
    logic       D_o;
    logic       SN_o;
    logic       CLKN_o;
    logic       Q_i;
    logic       QN_i;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;

    modport master (
        input  start, Q_i, QN_i,
        output D_o, SN_o, CLKN_o, busy, done, pass, err_count
    );

    modport slave (
        output start, Q_i, QN_i,
        input  D_o, SN_o, CLKN_o, busy, done, pass, err_count
    );
endinterface

// File: rtl/dffsn_stim_checker.sv
// Self-contained stimulus generator and checker for a negative-edge DFF
// with active-low asynchronous set.  Each run drives NUM_VEC pseudo-random
// data vectors (8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1) through
// SETUP/CAPTURE/CHECK and, after every SET_EVERY-th vector, a set pulse
// through SET/SETCHK.  Mismatches are counted in a saturating 8-bit counter.
//
// Ports:
//   CLK  : clock, all state on the rising edge
//   R    : synchronous active-high reset, wins over start
//   bus  : dffsn_stim_checker_if.master (start, flop drives/outputs, status)
//
// Optional feature: define DFFSN_STIM_QN_CHECK_EN to also require QN_i==~Q_i
// in CHECK and SETCHK.  Without it QN_i is ignored.
module dffsn_stim_checker #(
    parameter int         NUM_VEC   = 64,
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter int         SET_EVERY = 8
) (
    input logic                   CLK,
    input logic                   R,
    dffsn_stim_checker_if.master  bus
);

    // An all-zero seed would lock the LFSR up.
    localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    typedef enum logic [2:0] {
        IDLE, SETUP, CAPTURE, CHECK, SET, SETCHK, DONE
    } state_t;

    state_t     state;
    logic [7:0] lfsr;
    logic [7:0] vec_cnt;
    logic [7:0] set_cnt;   // vectors since the last set check
    logic       exp_q;

    logic [7:0] lfsr_next;
    logic [7:0] vec_next;
    logic       set_due;
    logic       qn_bad;
    logic       mismatch;
    logic [7:0] err_upd;

    assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign vec_next  = vec_cnt + 8'd1;
    assign set_due   = (set_cnt == 8'(SET_EVERY - 1));

`ifdef DFFSN_STIM_QN_CHECK_EN
    assign qn_bad = (bus.QN_i == bus.Q_i);
`else
    // QN_i is deliberately ignored in this build.
    assign qn_bad = bus.QN_i & 1'b0;
`endif

    // A Q error and a QN error in the same check cost one count.
    always_comb begin
        mismatch = 1'b0;
        case (state)
            CHECK:   mismatch = (bus.Q_i != exp_q) || qn_bad;
            SETCHK:  mismatch = !bus.Q_i || qn_bad;
            default: mismatch = 1'b0;
        endcase
        err_upd = bus.err_count;
        if (mismatch && bus.err_count != 8'hFF)
            err_upd = bus.err_count + 8'd1;
    end

    // Outputs are registered: each transition loads the drive values that
    // belong to the state being entered.
    always_ff @(posedge CLK) begin
        if (R) begin
            state         <= IDLE;
            lfsr          <= SEED;
            vec_cnt       <= 8'd0;
            set_cnt       <= 8'd0;
            exp_q         <= 1'b0;
            bus.D_o       <= 1'b0;
            bus.SN_o      <= 1'b1;
            bus.CLKN_o    <= 1'b1;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.pass      <= 1'b0;
            bus.err_count <= 8'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state         <= SETUP;
                        lfsr          <= SEED;
                        vec_cnt       <= 8'd0;
                        set_cnt       <= 8'd0;
                        exp_q         <= SEED[0];
                        bus.D_o       <= SEED[0];
                        bus.SN_o      <= 1'b1;
                        bus.CLKN_o    <= 1'b1;
                        bus.busy      <= 1'b1;
                        bus.done      <= 1'b0;
                        bus.pass      <= 1'b0;
                        bus.err_count <= 8'd0;
                    end
                end
                SETUP: begin
                    state      <= CAPTURE;
                    bus.CLKN_o <= 1'b0;   // falling edge captures D_o
                end
                CAPTURE: begin
                    state <= CHECK;
                end
                CHECK: begin
                    bus.err_count <= err_upd;
                    lfsr          <= lfsr_next;
                    vec_cnt       <= vec_next;
                    bus.CLKN_o    <= 1'b1;
                    // The set check takes precedence even after the last vector.
                    if (set_due) begin
                        state    <= SET;
                        set_cnt  <= 8'd0;
                        bus.SN_o <= 1'b0;
                        bus.D_o  <= 1'b0;
                    end else begin
                        set_cnt <= set_cnt + 8'd1;
                        if (vec_next == 8'(NUM_VEC)) begin
                            state    <= DONE;
                            bus.D_o  <= 1'b0;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            bus.pass <= (err_upd == 8'd0);
                        end else begin
                            state   <= SETUP;
                            exp_q   <= lfsr_next[0];
                            bus.D_o <= lfsr_next[0];
                        end
                    end
                end
                SET: begin
                    state    <= SETCHK;
                    bus.SN_o <= 1'b1;
                end
                SETCHK: begin
                    bus.err_count <= err_upd;
                    // vec_cnt and lfsr were already advanced in CHECK.
                    if (vec_cnt == 8'(NUM_VEC)) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.pass <= (err_upd == 8'd0);
                    end else begin
                        state   <= SETUP;
                        exp_q   <= lfsr[0];
                        bus.D_o <= lfsr[0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dffsn_stim_checker.md
DFFSN_STIM_CHECKER -- requirements
Module: dffsn_stim_checker

Interface
REQ-001 Parameter NUM_VEC, default 64, number of data vectors per run (1..255).
REQ-002 Parameter LFSR_SEED, default 8'hA5, initial 8-bit LFSR state; value 0 SHALL be replaced by 8'h01.
REQ-003 Parameter SET_EVERY, default 8, a set check is inserted after every SET_EVERY-th data vector (1..NUM_VEC).
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 R  input  1  reset; synchronous and active-high.
REQ-006 start  input  1  one-cycle request to begin a run.
REQ-007 D_o  output  1  data drive to DUT flop D.
REQ-008 SN_o  output  1  active-low set drive to DUT flop SN.
REQ-009 CLKN_o  output  1  negative-edge clock drive to DUT flop CLKN.
REQ-010 Q_i, QN_i  input  1 each  DUT flop outputs.
REQ-011 busy  output  1  high while a run is in progress.
REQ-012 done  output  1  high from run end until next start or reset.
REQ-013 pass  output  1  valid when done; high iff err_count==0.
REQ-014 err_count  output  8  mismatch count, saturating at 255.

Function
REQ-015 FSM states SHALL be IDLE, SETUP, CAPTURE, CHECK, SET, SETCHK, DONE.
REQ-016 IDLE/DONE + start: clear err_count, vector count, load LFSR from LFSR_SEED, go SETUP; busy=1, done=0 from the next cycle.
REQ-017 start while busy SHALL be ignored.
REQ-018 SETUP (1 cycle): D_o=LFSR[0], CLKN_o=1, SN_o=1; expected value register <= LFSR[0].
REQ-019 CAPTURE (1 cycle): CLKN_o=0 (falling edge captures D_o in DUT); D_o held.
REQ-020 CHECK (1 cycle): CLKN_o=0; Q_i compared to expected; mismatch increments err_count; LFSR advances (x^8+x^6+x^5+x^4+1, Fibonacci, shift left, feedback into bit 0); vector count increments.
REQ-021 After CHECK: if vector count is a multiple of SET_EVERY go SET; else if count==NUM_VEC go DONE; else go SETUP.
REQ-022 SET (1 cycle): SN_o=0, CLKN_o=1, D_o=0.
REQ-023 SETCHK (1 cycle): SN_o=1, CLKN_o=1; Q_i compared to 1, mismatch increments err_count; then DONE if count==NUM_VEC else SETUP.
REQ-024 Each data vector SHALL take exactly 3 cycles; each set check exactly 2 cycles; total run length = 3*NUM_VEC + 2*floor(NUM_VEC/SET_EVERY) cycles from first SETUP to DONE entry.
REQ-025 DONE: busy=0, done=1, pass=(err_count==0); all drives at reset values.
REQ-026 err_count SHALL saturate at 255; further mismatches hold it.
REQ-027 Two mismatches in one CHECK (see REQ-031) SHALL count as one.

Reset
REQ-028 R=1 SHALL force next cycle: state IDLE, D_o=0, SN_o=1, CLKN_o=1, busy=0, done=0, pass=0, err_count=0, LFSR=seed.
REQ-029 R SHALL take priority over start, including mid-run; run is abandoned, no partial result kept.
REQ-030 R and start both high: reset wins; start ignored.

Configuration
REQ-031 Macro DFFSN_STIM_QN_CHECK_EN: when defined, CHECK and SETCHK additionally require QN_i==~Q_i, any violation counted per REQ-027; when undefined, QN_i is unused and only Q_i is checked.

Verification
REQ-032 Ideal flop model, NUM_VEC=64, SET_EVERY=8, start pulse -> done after 208 cycles, pass=1, err_count=0.
REQ-033 Q_i tied 0 -> err_count equals number of 1 vectors plus 8 set checks, pass=0.
REQ-034 NUM_VEC=255, SET_EVERY=1, Q_i tied inverted -> err_count saturates at 255.
REQ-035 R asserted in cycle 10 of a run -> IDLE next cycle, all outputs at reset values; new start completes with pass=1.
REQ-036 With DFFSN_STIM_QN_CHECK_EN defined, QN_i tied equal to Q_i on ideal model -> err_count=72, pass=0; undefined -> pass=1.
